// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack
// handshake to instruction memory and drives the IF/ID register. A one-entry
// skid buffer absorbs a response that arrives while ID is stalled; a redirect
// flushes IF/ID and marks any in-flight request stale so its response is dropped.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0010_0008,
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallf,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  // IDLE: no request yet, BUSY: live request outstanding,
  // HOLD: response parked in skid, DROP: outstanding request is stale
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD, S_DROP} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               id_valid_q;
  logic [ADDR_W-1:0]  id_pc_q;
  logic [INSTR_W-1:0] id_instr_q;
  logic [ADDR_W-1:0]  skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;

  logic               slot_free_d;
  logic               ack_d;
  logic [ADDR_W-1:0]  addr_inc_d;

  // Responses only count while a request is actually outstanding
  assign slot_free_d = !id_valid_q || !stallf;
  assign ack_d       = imem_ack && req_q;
  assign addr_inc_d  = addr_q + STEP;

  // Fetch FSM with registered memory-side and IF/ID outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else if (redirect) begin
      // Redirect beats everything, including a stall; skid is abandoned by leaving HOLD
      pc_q       <= redirect_pc;
      id_valid_q <= 1'b0;
      if (state_q == S_IDLE || state_q == S_HOLD || ack_d) begin
        // Nothing outstanding (or it just completed): issue the new target at once
        state_q <= S_BUSY;
        req_q   <= 1'b1;
        addr_q  <= redirect_pc;
      end else begin
        // Request still in flight: keep the handshake stable, discard its response later
        state_q <= S_DROP;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_BUSY;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
          if (slot_free_d) id_valid_q <= 1'b0;
        end
        S_BUSY: begin
          if (ack_d) begin
            pc_q <= addr_inc_d;
            if (slot_free_d) begin
              id_valid_q <= 1'b1;
              id_pc_q    <= addr_q;
              id_instr_q <= imem_rdata;
              addr_q     <= addr_inc_d;
            end else begin
              skid_pc_q    <= addr_q;
              skid_instr_q <= imem_rdata;
              req_q        <= 1'b0;
              state_q      <= S_HOLD;
            end
          end else if (slot_free_d) begin
            id_valid_q <= 1'b0;
          end
        end
        S_HOLD: begin
          if (slot_free_d) begin
            id_valid_q <= 1'b1;
            id_pc_q    <= skid_pc_q;
            id_instr_q <= skid_instr_q;
            req_q      <= 1'b1;
            addr_q     <= pc_q;
            state_q    <= S_BUSY;
          end
        end
        S_DROP: begin
          if (ack_d) begin
            addr_q  <= pc_q;
            state_q <= S_BUSY;
          end
          if (slot_free_d) id_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;

endmodule
